// File: rtl/mu_issue_ctrl.sv
// mu_issue_ctrl: issues one multiply op to the multiply unit, buffers its result for writeback and stalls decode on RAW hazards.
// Define MU_WB_BYPASS_EN to add fwd_* forwarding from the WB buffer and back-to-back accept on wb_ack.
package mu_issue_ctrl_pkg;
   typedef logic [1:0] sign_type_t;
endpackage

module mu_issue_ctrl
   import mu_issue_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [XLEN-1:0]  issue_rs1_data,
   input  logic [XLEN-1:0]  issue_rs2_data,
   input  logic             issue_high_low_sel,
   input  sign_type_t       issue_is_signed,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_wen,
   input  logic [REG_W-1:0] src1_idx,
   input  logic [REG_W-1:0] src2_idx,
   input  logic             flush,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic             start_mu,
   output logic             decode_done,
   output logic             high_low_sel,
   output sign_type_t       is_signed,
   output logic [REG_W-1:0] reg_rd,
   output logic             wen,
   input  logic             busy_mu,
   input  logic             done_mu,
   input  logic             wen_mu,
   input  logic [XLEN-1:0]  wdata_mu,
   input  logic [REG_W-1:0] reg_rd_mu,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_rd,
   output logic [XLEN-1:0]  wb_data,
   input  logic             wb_ack,
   output logic             hazard_stall
`ifdef MU_WB_BYPASS_EN
   ,
   output logic             fwd_valid,
   output logic [REG_W-1:0] fwd_rd,
   output logic [XLEN-1:0]  fwd_data
`endif
);
   typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;
   state_t state, state_nxt;
   logic kill, pending_valid, op_hl, op_wen, ready_int, accept, take_result, hit;
   logic [XLEN-1:0] op_rs1, op_rs2, buf_data;
   logic [REG_W-1:0] op_rd, buf_rd;
   sign_type_t op_sgn;
   logic [5:0] idle_cnt;

`ifdef MU_WB_BYPASS_EN
   assign ready_int = state == IDLE || (state == WB && wb_ack);
`else
   assign ready_int = state == IDLE;
`endif
   assign accept      = ready_int && issue_valid && !flush;
   assign take_result = done_mu && !kill && !flush && wen_mu && reg_rd_mu != '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? START : IDLE;
         START:   state_nxt = busy_mu ? START : WAIT;
         WAIT:    state_nxt = !done_mu ? WAIT : take_result ? WB : IDLE;
         WB:      state_nxt = flush ? IDLE : accept ? START : wb_ack ? IDLE : WB;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state         <= IDLE;
         kill          <= 1'b0;
         pending_valid <= 1'b0;
         op_rs1        <= '0;
         op_rs2        <= '0;
         op_hl         <= 1'b0;
         op_sgn        <= '0;
         op_rd         <= '0;
         op_wen        <= 1'b0;
         buf_rd        <= '0;
         buf_data      <= '0;
         idle_cnt      <= '0;
      end else begin
         state         <= state_nxt;
         pending_valid <= state_nxt != IDLE;
         // The multiply unit cannot be aborted, so a flushed op is only marked dead until done_mu
         kill          <= state_nxt == IDLE ? 1'b0 : kill || (flush && (state == START || state == WAIT));
         if (accept) begin
            op_rs1 <= issue_rs1_data;
            op_rs2 <= issue_rs2_data;
            op_hl  <= issue_high_low_sel;
            op_sgn <= issue_is_signed;
            op_rd  <= issue_rd;
            op_wen <= issue_wen;
         end
         if (take_result) begin
            buf_rd   <= reg_rd_mu;
            buf_data <= wdata_mu;
         end
         idle_cnt <= (state == WAIT && !busy_mu) ? idle_cnt + 6'd1 : '0;
      end

   assign rs1_data     = op_rs1;
   assign rs2_data     = op_rs2;
   assign high_low_sel = op_hl;
   assign is_signed    = op_sgn;
   assign reg_rd       = op_rd;
   assign wen          = op_wen;
   assign start_mu     = state == START && !busy_mu;
   assign decode_done  = start_mu;
   assign wb_valid     = state == WB;
   assign wb_rd        = buf_rd;
   assign wb_data      = buf_data;
   assign issue_ready  = !RST && ready_int;
   assign hit = pending_valid && !kill && op_rd != '0 && (src1_idx == op_rd || src2_idx == op_rd);

`ifdef MU_WB_BYPASS_EN
   assign hazard_stall = !RST && ((hit && state != WB) || (issue_valid && !ready_int));
   assign fwd_valid    = state == WB;
   assign fwd_rd       = buf_rd;
   assign fwd_data     = buf_data;
`else
   assign hazard_stall = !RST && (hit || (issue_valid && !ready_int));
`endif

   // A multiply unit that never reports busy for 64 cycles while we wait has lost the op
   a_busy_seen: assert property (@(posedge CLK) disable iff (RST)
      !(state == WAIT && !busy_mu && idle_cnt == 6'd63));
endmodule

// File: tb/tb_mu_issue_ctrl.sv
// tb_mu_issue_ctrl: directed vectors for mu_issue_ctrl with hand-computed expectations.
module tb_mu_issue_ctrl;
   import mu_issue_ctrl_pkg::*;
   localparam int XLEN = 32, REG_W = 5;
   logic CLK = 0, RST = 1;
   logic issue_valid = 0, issue_high_low_sel = 0, issue_wen = 0, flush = 0;
   logic [XLEN-1:0] issue_rs1_data = 0, issue_rs2_data = 0, wdata_mu = 0;
   sign_type_t issue_is_signed = 0;
   logic [REG_W-1:0] issue_rd = 0, src1_idx = 0, src2_idx = 0, reg_rd_mu = 0;
   logic busy_mu = 0, done_mu = 0, wen_mu = 0, wb_ack = 0;
   logic issue_ready, start_mu, decode_done, high_low_sel, wen, wb_valid, hazard_stall;
   logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
   logic [REG_W-1:0] reg_rd, wb_rd;
   sign_type_t is_signed;
`ifdef MU_WB_BYPASS_EN
   logic fwd_valid;
   logic [REG_W-1:0] fwd_rd;
   logic [XLEN-1:0] fwd_data;
   localparam logic WB_STALL = 1'b0;
`else
   localparam logic WB_STALL = 1'b1;
`endif
   int n_vec = 0, n_err = 0;

   mu_issue_ctrl #(.XLEN(XLEN), .REG_W(REG_W)) dut (
      .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
      .issue_high_low_sel(issue_high_low_sel), .issue_is_signed(issue_is_signed),
      .issue_rd(issue_rd), .issue_wen(issue_wen), .src1_idx(src1_idx), .src2_idx(src2_idx),
      .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data), .start_mu(start_mu),
      .decode_done(decode_done), .high_low_sel(high_low_sel), .is_signed(is_signed),
      .reg_rd(reg_rd), .wen(wen), .busy_mu(busy_mu), .done_mu(done_mu), .wen_mu(wen_mu),
      .wdata_mu(wdata_mu), .reg_rd_mu(reg_rd_mu), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_ack(wb_ack), .hazard_stall(hazard_stall)
`ifdef MU_WB_BYPASS_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic issue_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [REG_W-1:0] rd, input logic hl);
      issue_rs1_data = a;
      issue_rs2_data = b;
      issue_rd = rd;
      issue_high_low_sel = hl;
      issue_is_signed = 2'b01;
      issue_wen = 1;
      issue_valid = 1;
      tick;
      issue_valid = 0;
      #1;
   endtask

   initial begin
      issue_valid = 1;
      #1;
      chk("rst_ready", issue_ready, 0);
      chk("rst_stall", hazard_stall, 0);
      chk("rst_start", start_mu, 0);
      chk("rst_wb_valid", wb_valid, 0);
      issue_valid = 0;
      #11 RST = 0;
      tick;
      chk("idle_ready", issue_ready, 1);
      // basic op: 7 * 6, rd=5, low half
      issue_op(32'h7, 32'h6, 5'd5, 1'b0);
      chk("start_pulse", start_mu, 1);
      chk("decode_done", decode_done, 1);
      chk("op_rs1", rs1_data, 32'h7);
      chk("op_rs2", rs2_data, 32'h6);
      chk("op_rd", reg_rd, 5);
      chk("op_wen", wen, 1);
      chk("op_sign", is_signed, 2'b01);
      chk("op_hl", high_low_sel, 0);
      chk("start_not_ready", issue_ready, 0);
      tick;
      busy_mu = 1;
      #1;
      chk("start_one_cycle", start_mu, 0);
      repeat (3) begin
         tick;
         chk("no_restart", start_mu, 0);
      end
      done_mu = 1; busy_mu = 0; wen_mu = 1; reg_rd_mu = 5; wdata_mu = 32'h2A;
      #1;
      chk("wb_not_yet", wb_valid, 0);
      tick;
      done_mu = 0;
      #1;
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", wb_rd, 5);
      chk("wb_data", wb_data, 32'h2A);
      // backpressure with a competing issue request and a decode hazard on rd 5
      issue_valid = 1; src2_idx = 5; issue_rs1_data = 32'h99;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_data", wb_data, 32'h2A);
         chk("bp_ready", issue_ready, 0);
         chk("bp_stall", hazard_stall, 1);
         tick;
      end
      issue_valid = 0; wb_ack = 1;
      #1;
      chk("ack_wb_valid", wb_valid, 1);
      chk("ack_stall", hazard_stall, WB_STALL);
      tick;
      wb_ack = 0;
      #1;
      chk("post_ack_wb", wb_valid, 0);
      chk("post_ack_ready", issue_ready, 1);
      chk("post_ack_stall", hazard_stall, 0);
      chk("no_second_accept", rs1_data, 32'h7);
      // hazard on rd 10 through the whole op
      src2_idx = 10;
      issue_op(32'h3, 32'h4, 5'd10, 1'b1);
      chk("haz_start", hazard_stall, 1);
      tick;
      busy_mu = 1;
      #1;
      chk("haz_wait", hazard_stall, 1);
      done_mu = 1; busy_mu = 0; reg_rd_mu = 10; wdata_mu = 32'h64; wen_mu = 1;
      tick;
      done_mu = 0;
      #1;
      chk("haz_wb_valid", wb_valid, 1);
      chk("haz_wb", hazard_stall, WB_STALL);
      wb_ack = 1;
      tick;
      wb_ack = 0;
      #1;
      chk("haz_clear", hazard_stall, 0);
      // rd 0: never stalls, never writes back
      src2_idx = 0;
      issue_op(32'h1, 32'h1, 5'd0, 1'b0);
      chk("rd0_stall", hazard_stall, 0);
      tick;
      done_mu = 1; reg_rd_mu = 0; wen_mu = 1;
      tick;
      done_mu = 0;
      #1;
      chk("rd0_no_wb", wb_valid, 0);
      chk("rd0_idle", issue_ready, 1);
      // flush in IDLE rejects the op
      issue_valid = 1; flush = 1; issue_rs1_data = 32'hBAD;
      tick;
      issue_valid = 0; flush = 0;
      #1;
      chk("idle_flush_start", start_mu, 0);
      chk("idle_flush_regs", rs1_data, 32'h1);
      // flush two cycles after start
      src1_idx = 7;
      issue_op(32'h5, 32'h5, 5'd7, 1'b0);
      tick;
      busy_mu = 1;
      #1;
      chk("fl_stall_pre", hazard_stall, 1);
      tick;
      flush = 1;
      tick;
      flush = 0;
      #1;
      chk("fl_stall_killed", hazard_stall, 0);
      chk("fl_still_busy", issue_ready, 0);
      repeat (3) tick;
      done_mu = 1; busy_mu = 0; wdata_mu = 32'hDEAD; reg_rd_mu = 7; wen_mu = 1;
      tick;
      done_mu = 0;
      #1;
      chk("fl_no_wb", wb_valid, 0);
      chk("fl_idle", issue_ready, 1);
      tick;
      chk("fl_no_wb_later", wb_valid, 0);
      // async reset in WAIT
      src1_idx = 9;
      issue_op(32'h1234, 32'h2, 5'd9, 1'b0);
      tick;
      busy_mu = 1;
      #1;
      chk("ar_stall_pre", hazard_stall, 1);
      #1 RST = 1;
      #1;
      chk("ar_rs1", rs1_data, 0);
      chk("ar_rd", reg_rd, 0);
      chk("ar_wen", wen, 0);
      chk("ar_ready", issue_ready, 0);
      chk("ar_stall", hazard_stall, 0);
      #2 RST = 0;
      done_mu = 1; busy_mu = 0; reg_rd_mu = 9; wen_mu = 1; wdata_mu = 32'h77;
      tick;
      done_mu = 0;
      #1;
      chk("ar_done_ignored", wb_valid, 0);
      chk("ar_no_start", start_mu, 0);
      chk("ar_idle", issue_ready, 1);
`ifdef MU_WB_BYPASS_EN
      src1_idx = 3;
      issue_op(32'h2, 32'h3, 5'd3, 1'b0);
      tick;
      done_mu = 1; reg_rd_mu = 3; wen_mu = 1; wdata_mu = 32'h55;
      tick;
      done_mu = 0;
      #1;
      chk("fwd_valid", fwd_valid, 1);
      chk("fwd_rd", fwd_rd, 3);
      chk("fwd_data", fwd_data, 32'h55);
      chk("fwd_no_stall", hazard_stall, 0);
      issue_rs1_data = 32'h11; issue_rd = 4; issue_valid = 1; wb_ack = 1;
      #1;
      chk("b2b_ready", issue_ready, 1);
      tick;
      issue_valid = 0; wb_ack = 0;
      #1;
      chk("b2b_start", start_mu, 1);
      chk("b2b_rs1", rs1_data, 32'h11);
      tick;
      done_mu = 1; wen_mu = 0;
      tick;
      done_mu = 0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
